d_debouncer: RTL
================

# d_debouncer

Input conditioning stage that sits directly upstream of the D flip-flop capture stage and drives its `d` input. It takes a raw, asynchronous, possibly glitchy level, synchronizes it into the `clock` domain and filters out pulses shorter than a programmable number of cycles. It presents a clean level plus one-cycle rise and fall strobes. A saturating counter reports the number of rejected glitches for debug.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive synchronized samples required to accept a new level. Legal range is 2..255.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clock` in 1: single clock; all state is updated on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `d_raw` in 1: raw asynchronous input level.
- `enable` in 1: when 0, level changes are not accepted.
- `d_clean` out 1: filtered level; connects to the downstream capture stage `d`.
- `rise` out 1: one-cycle strobe when `d_clean` goes 0→1.
- `fall` out 1: one-cycle strobe when `d_clean` goes 1→0.
- `busy` out 1: high while a candidate level change is being qualified.
- `glitch_count` out `GLITCH_W`: number of rejected candidates, saturating.

## Operation
- Reset (`reset_n`=0, asynchronous) forces:
  - `sync1`, `sync2`, `d_clean`, `rise`, `fall`, `busy`, `glitch_count` to 0
  - state to `STABLE_LO`
  - the qualification counter `cnt` to 0
- Synchronizer: two flops, `d_raw`→`sync1`→`sync2`. The FSM sees only `sync2` (called `s`). The synchronizer runs regardless of `enable`.
- FSM states: `STABLE_LO`, `CHK_HI`, `STABLE_HI`, `CHK_LO`.
  - `STABLE_LO`: if `s`=1 and `enable`=1, go to `CHK_HI` with `cnt`=1.
  - `CHK_HI`, `s`=1: if `cnt`==`STABLE_CYCLES`−1, go to `STABLE_HI`, set `d_clean`=1 and pulse `rise`. Otherwise increment `cnt`.
  - `CHK_HI`, `s`=0: go to `STABLE_LO` and increment `glitch_count` (saturating).
  - `STABLE_HI` and `CHK_LO` mirror the above with the polarity inverted and `fall` pulsed instead of `rise`.
- `enable` deasserted while in a `CHK_*` state: return to the matching `STABLE_*` state next edge. `glitch_count` is not incremented and no strobe is produced.
- `busy` is 1 exactly in the `CHK_HI` and `CHK_LO` states.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- `glitch_count` holds at 2^`GLITCH_W`−1 once reached; it does not wrap.
- `cnt` is sized as clog2(`STABLE_CYCLES`) bits and is cleared on every return to a `STABLE_*` state.

## Timing
- Latency: `d_raw` first sampled high at edge N and held → `d_clean` and `rise` are high after edge N+`STABLE_CYCLES`+1. Fall latency is identical.
- Acceptance requires `s` to be high at `STABLE_CYCLES` consecutive edges. A pulse that yields fewer samples is rejected and counted once.
- A pulse shorter than one clock period may be missed entirely by the synchronizer. That is legal: no strobe and no count.
- A level change exactly on the qualifying edge (`s` toggles back on edge N+`STABLE_CYCLES`+1) is rejected. Acceptance needs the sample on that edge.
- Reset asserted mid-qualification: all outputs go to 0 immediately. After `reset_n` rises, a held-high `d_raw` is re-qualified from scratch, so `d_clean` rises `STABLE_CYCLES`+2 edges after the first post-reset edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `debounce_pkg` holds the 2-bit state encoding constants (`ST_STABLE_LO`=0, `ST_CHK_HI`=1, `ST_STABLE_HI`=2, `ST_CHK_LO`=3) and the default `STABLE_CYCLES`.
- One sub-module: `sync_2ff`, a two-flop synchronizer with async active-low reset to 0. It is reused by later input stages.
- The FSM, `cnt`, the strobes and the glitch counter live in `d_debouncer`.

## Test plan
Defaults for all scenarios: 10 ns clock, `STABLE_CYCLES`=4, `enable`=1.

1. Reset then idle: `reset_n`=0 for 12 ns, then `d_raw`=0 → all outputs 0, `glitch_count`=0 throughout.
2. Clean rise: `d_raw` goes 0→1 before edge N and is held → `busy` high from edge N+2, `d_clean`=1 and `rise`=1 after edge N+5, `rise`=0 after edge N+6.
3. Glitch burst (4 ns wide pulses spaced 7 ns) → `d_clean` stays 0, no strobes, `glitch_count` increments by the number of captured pulses (≥1).
4. Two-cycle pulse: `d_raw` high for 20 ns → rejected, `glitch_count`=1, `d_clean`=0. A following five-cycle pulse → accepted, `rise` then `fall` one cycle each, `fall` 5 edges after the drop is sampled.
5. Mid-operation: with `d_raw` held high, assert `reset_n`=0 two edges after `busy` rises → outputs 0 asynchronously; after release, `d_clean` rises 6 edges later. Separately, `enable`=0 during `CHK_HI` → back to `STABLE_LO`, `glitch_count` unchanged.
6. Saturation with `GLITCH_W`=2: inject 5 single-sample glitches → `glitch_count`=3 and holds there.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for debounced input stages: FSM state encoding and default qualification length.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHK_HI    = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHK_LO    = 2'd3
  } state_t;

  localparam int STABLE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 cycles. No backpressure.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic stage1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1 <= 1'b0;
      q      <= 1'b0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/d_debouncer.sv
// Synchronizes and debounces a raw level; emits clean level, rise/fall strobes and a saturating glitch count.
// Latency: STABLE_CYCLES+2 edges from first raw sample to d_clean. No backpressure.
module d_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int GLITCH_W      = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                d_raw,
  input  logic                enable,
  output logic                d_clean,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int             CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  state_t        state;
  logic [CW-1:0] cnt;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (d_raw),
    .q       (s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_STABLE_LO;
      cnt          <= '0;
      d_clean      <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      busy         <= 1'b0;
      glitch_count <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE_LO: begin
          if (s && enable) begin
            state <= ST_CHK_HI;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        ST_CHK_HI: begin
          // Losing enable abandons the candidate silently; it is not a glitch.
          if (!enable) begin
            state <= ST_STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (s) begin
            if (cnt == CNT_LAST) begin
              state   <= ST_STABLE_HI;
              cnt     <= '0;
              busy    <= 1'b0;
              d_clean <= 1'b1;
              rise    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= ST_STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_count != '1) glitch_count <= glitch_count + 1'b1;
          end
        end
        ST_STABLE_HI: begin
          if (!s && enable) begin
            state <= ST_CHK_LO;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        ST_CHK_LO: begin
          if (!enable) begin
            state <= ST_STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (!s) begin
            if (cnt == CNT_LAST) begin
              state   <= ST_STABLE_LO;
              cnt     <= '0;
              busy    <= 1'b0;
              d_clean <= 1'b0;
              fall    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= ST_STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_count != '1) glitch_count <= glitch_count + 1'b1;
          end
        end
        default: begin
          state <= ST_STABLE_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
